// File: rtl/systolic_array_ctrl_pkg.sv
// Shared types and constants for the systolic array sequencer.
package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    COMPUTE,
    DRAIN,
    DONE
  } state_t;

  localparam int unsigned ARRAY_N_DEF  = 16;
  localparam int unsigned PIPE_LAT_DEF = 16;

  // Cycles needed after the last activation read to flush every valid line.
  function automatic int unsigned drain_cycles(input int unsigned n, input int unsigned lat);
    return n + lat;
  endfunction

endpackage

// File: rtl/systolic_array_ctrl_valid_skew_line.sv
// Single-bit shift register of DEPTH stages; used for per-lane skew and array latency.
module valid_skew_line #(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic sclr,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sr <= '0;
    end else if (sclr) begin
      sr <= '0;
    end else begin
      sr <= (sr << 1) | DEPTH'(d);
    end
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/systolic_array_ctrl.sv
// Weight-stationary systolic array sequencer: weight load, activation streaming, valid skew.
// Optional busy-cycle counter enabled by SYSTOLIC_CTRL_PERF_EN.
module systolic_array_ctrl
  import systolic_pkg::*;
#(
  parameter int unsigned ARRAY_N  = ARRAY_N_DEF,
  parameter int unsigned CNT_BW   = 8,
  parameter int unsigned PIPE_LAT = PIPE_LAT_DEF,
  parameter int unsigned ROW_BW   = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic               reuse_w,
  input  logic [CNT_BW-1:0]  num_vec,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               w_rd_en,
  output logic [ROW_BW-1:0]  w_rd_addr,
  output logic [ARRAY_N-1:0] we_rl,
  output logic               x_rd_en,
  output logic [CNT_BW-1:0]  x_rd_addr,
  output logic [ARRAY_N-1:0] in_valid,
  output logic [ARRAY_N-1:0] out_valid
`ifdef SYSTOLIC_CTRL_PERF_EN
  ,
  output logic [31:0]        perf_cycles
`endif
);

  localparam int unsigned DRAIN_CYCLES = drain_cycles(ARRAY_N, PIPE_LAT);
  localparam int unsigned DRN_BW       = $clog2(DRAIN_CYCLES);
  localparam int unsigned CW0          = (CNT_BW > ROW_BW + 1) ? CNT_BW : ROW_BW + 1;
  localparam int unsigned CW           = (CW0 > DRN_BW) ? CW0 : DRN_BW;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CNT_BW-1:0] nv_q, nv_d;
  logic              w_en_d, x_en_d;

  // Next state; cnt counts cycles spent in the current state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    nv_d    = nv_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          nv_d = num_vec;
          if (num_vec == '0)  state_d = DONE;
          else if (reuse_w)   state_d = COMPUTE;
          else                state_d = LOAD_W;
        end
      end
      LOAD_W: begin
        if (cnt_q == CW'(ARRAY_N)) begin
          state_d = COMPUTE;
          cnt_d   = '0;
        end
      end
      COMPUTE: begin
        if (cnt_q == CW'(nv_q) - CW'(1)) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        if (cnt_q == CW'(DRAIN_CYCLES - 1)) begin
          state_d = DONE;
          cnt_d   = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
      nv_d    = nv_q;
    end
    w_en_d = (state_d == LOAD_W) && (cnt_d < CW'(ARRAY_N));
    x_en_d = (state_d == COMPUTE);
  end

  // Outputs are registered from the next-state view so they line up with the state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      nv_q      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      w_rd_en   <= 1'b0;
      w_rd_addr <= '0;
      we_rl     <= '0;
      x_rd_en   <= 1'b0;
      x_rd_addr <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      nv_q      <= nv_d;
      busy      <= (state_d != IDLE);
      done      <= (state_d == DONE);
      w_rd_en   <= w_en_d;
      w_rd_addr <= w_en_d ? cnt_d[ROW_BW-1:0] : '0;
      we_rl     <= (w_rd_en && !abort) ? (ARRAY_N'(1) << w_rd_addr) : '0;
      x_rd_en   <= x_en_d;
      x_rd_addr <= x_en_d ? cnt_d[CNT_BW-1:0] : '0;
    end
  end

  for (genvar i = 0; i < ARRAY_N; i++) begin : g_lane
    valid_skew_line #(.DEPTH(i + 1)) u_in_skew (
      .clk  (clk),
      .rstn (rstn),
      .sclr (abort),
      .d    (x_rd_en),
      .q    (in_valid[i])
    );
    valid_skew_line #(.DEPTH(PIPE_LAT)) u_out_lat (
      .clk  (clk),
      .rstn (rstn),
      .sclr (abort),
      .d    (in_valid[i]),
      .q    (out_valid[i])
    );
  end

`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0] perf_cnt, perf_nxt;

  always_comb begin
    perf_nxt = (state_d == IDLE) ? 32'd0 : perf_cnt + 32'd1;
  end

  // Running busy count; snapshot taken as the DONE cycle begins.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_cnt    <= 32'd0;
      perf_cycles <= 32'd0;
    end else begin
      perf_cnt <= perf_nxt;
      if (state_d == DONE) perf_cycles <= perf_nxt;
    end
  end
`endif

endmodule
